intr_ctrl: RTL and testbench
============================

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameters: none; 8 request lines, fixed.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 irq_in  input  8  external interrupt request lines, asynchronous, rising-edge triggered.
REQ-005 we_mask  input  1  mask write strobe from control unit.
REQ-006 mask_in  input  8  new mask value; bit=1 enables line.
REQ-007 ack  input  1  one-cycle pulse: control unit has vectored to the interrupt (pushes PC, asserts s_intr).
REQ-008 eoi  input  1  one-cycle pulse: return-from-interrupt executed.
REQ-009 intr  output  8  one-hot vector to datapath interrupt decoder; all-zero when int_req=0.
REQ-010 int_req  output  1  interrupt request to control unit.
REQ-011 pending  output  8  latched, not-yet-acknowledged requests (unmasked view).
REQ-012 in_service  output  1  interrupt handler active.
REQ-013 active_id  output  3  index of the line being serviced; valid while in_service=1.

Function
REQ-014 Each irq_in bit SHALL pass a 2-flop synchronizer (s1, s2), plus a history flop s3; edge = s2 & ~s3.
REQ-015 irq_in bit high at rising edge k, low before it, SHALL set its pending bit visible after edge k+2.
REQ-016 Pending bit SHALL remain set until cleared by ack for that line or reset; further edges while set have no effect.
REQ-017 Masked (mask=0) lines SHALL still latch pending but SHALL NOT contribute to int_req or intr.
REQ-018 int_req SHALL be combinational: OR of (pending & mask) AND NOT in_service.
REQ-019 intr SHALL be one-hot of the lowest-index set bit of (pending & mask) when int_req=1; bit 0 is highest priority.
REQ-020 FSM states: IDLE (in_service=0), SERVICE (in_service=1).
REQ-021 IDLE, ack=1 and int_req=1: clear selected pending bit, latch its index into active_id, go to SERVICE next edge.
REQ-022 ack with int_req=0 SHALL be ignored; no state change.
REQ-023 SERVICE, eoi=1: go to IDLE next edge; active_id holds last value.
REQ-024 eoi in IDLE SHALL be ignored; ack in SERVICE SHALL be ignored (no nesting).
REQ-025 ack and eoi in the same cycle: IDLE processes ack only; SERVICE processes eoi only.
REQ-026 New edge on the line being cleared by ack in the same cycle: set wins, pending bit stays 1.
REQ-027 we_mask=1 SHALL load mask_in at the edge; new mask affects int_req/intr from the following cycle; pending bits unaffected.
REQ-028 Mask changes during SERVICE SHALL NOT alter in_service or active_id.
REQ-029 Simultaneous edges on several lines SHALL all latch; serviced one per ack/eoi pair in priority order.

Reset
REQ-030 reset=1 at an edge SHALL clear s1, s2, s3, pending, mask (all lines disabled), active_id, and force IDLE; reset overrides all other inputs.
REQ-031 After reset: intr=8'h00, int_req=0, pending=8'h00, in_service=0, active_id=3'd0.
REQ-032 Reset mid-service SHALL abandon the service; no eoi required.
REQ-033 A line held high through reset release SHALL register one edge and set pending after release + 2 edges.

Verification
REQ-034 Reset, mask=8'hFF, pulse irq_in[3] at edge k -> pending=8'h08 and int_req=1, intr=8'h08 after edge k+2; ack -> pending=8'h00, in_service=1, active_id=3, int_req=0.
REQ-035 mask=8'hFF, edges on irq_in[5] and irq_in[1] same cycle -> intr=8'h02; ack, eoi -> intr=8'h20; ack -> active_id=5.
REQ-036 mask=8'h00, edge on irq_in[0] -> pending=8'h01, int_req=0; write mask=8'h01 -> int_req=1 next cycle.
REQ-037 In SERVICE, ack pulses and edge on irq_in[2] -> in_service stays 1, pending=8'h04, int_req=0; eoi -> int_req=1, intr=8'h04.
REQ-038 Edge on irq_in[4] arriving at pending in the cycle ack clears pending[4] -> pending[4]=1 after edge.
REQ-039 Assert reset while in_service=1 with pending=8'h81 -> all outputs zero next cycle, mask=8'h00.

Source files
------------

// File: rtl/intr_ctrl.sv
// Eight-line edge-triggered interrupt controller: synchronises requests, latches
// them as pending, and hands the highest-priority unmasked one to the control unit.
module intr_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irq_in,
    input  logic       we_mask,
    input  logic [7:0] mask_in,
    input  logic       ack,
    input  logic       eoi,
    output logic [7:0] intr,
    output logic       int_req,
    output logic [7:0] pending,
    output logic       in_service,
    output logic [2:0] active_id
);

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_SERVICE = 1'b1;

    logic       state;
    logic       state_next;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] s3;
    logic [7:0] mask;
    logic [7:0] rise;
    logic [7:0] masked;
    logic [2:0] sel;
    logic       take;
    logic [7:0] clear;
    logic [7:0] pending_next;

    assign rise       = s2 & ~s3;
    assign masked     = pending & mask;
    assign in_service = (state == ST_SERVICE);
    assign int_req    = (|masked) & ~in_service;
    assign intr       = int_req ? (8'd1 << sel) : '0;
    assign take       = (state == ST_IDLE) && ack && int_req;

    // Bit 0 is the highest priority.
    always_comb begin
        casez (masked)
            8'b???????1: sel = 3'd0;
            8'b??????10: sel = 3'd1;
            8'b?????100: sel = 3'd2;
            8'b????1000: sel = 3'd3;
            8'b???10000: sel = 3'd4;
            8'b??100000: sel = 3'd5;
            8'b?1000000: sel = 3'd6;
            8'b10000000: sel = 3'd7;
            default:     sel = 3'd0;
        endcase
    end

    // A fresh edge on the line being acknowledged wins over the clear.
    always_comb begin
        clear        = take ? (8'd1 << sel) : '0;
        pending_next = (pending & ~clear) | rise;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (take) state_next = ST_SERVICE;
            ST_SERVICE: if (eoi)  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            pending   <= '0;
            mask      <= '0;
            active_id <= '0;
            state     <= ST_IDLE;
        end else begin
            s1      <= irq_in;
            s2      <= s1;
            s3      <= s2;
            pending <= pending_next;
            state   <= state_next;
            if (we_mask) mask <= mask_in;
            if (take) active_id <= sel;
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: each step pushes the expected output snapshot,
// then the snapshot is popped and compared one cycle later.
module tb_intr_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_in;
    logic       we_mask;
    logic [7:0] mask_in;
    logic       ack;
    logic       eoi;
    logic [7:0] intr;
    logic       int_req;
    logic [7:0] pending;
    logic       in_service;
    logic [2:0] active_id;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] intr;
        logic       int_req;
        logic [7:0] pending;
        logic       in_service;
        logic [2:0] active_id;
    } exp_t;

    exp_t sb[$];

    intr_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .we_mask    (we_mask),
        .mask_in    (mask_in),
        .ack        (ack),
        .eoi        (eoi),
        .intr       (intr),
        .int_req    (int_req),
        .pending    (pending),
        .in_service (in_service),
        .active_id  (active_id)
    );

    always #5 clk = ~clk;

    task automatic expect_out(input string tag, input logic [7:0] e_intr, input logic e_req,
                              input logic [7:0] e_pend, input logic e_svc, input logic [2:0] e_id);
        exp_t e;
        e.tag = tag; e.intr = e_intr; e.int_req = e_req;
        e.pending = e_pend; e.in_service = e_svc; e.active_id = e_id;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input string field, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    // One clock edge, then compare the oldest queued expectation.
    task automatic tick_check();
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=%0d", 0, 1);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            cmp(e.tag, "intr",       intr,               e.intr);
            cmp(e.tag, "int_req",    {7'd0, int_req},    {7'd0, e.int_req});
            cmp(e.tag, "pending",    pending,            e.pending);
            cmp(e.tag, "in_service", {7'd0, in_service}, {7'd0, e.in_service});
            cmp(e.tag, "active_id",  {5'd0, active_id},  {5'd0, e.active_id});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; irq_in = '0; we_mask = 1'b0; mask_in = '0; ack = 1'b0; eoi = 1'b0;
        tick();
        expect_out("reset", 8'h00, 0, 8'h00, 0, 3'd0); tick_check();
        reset = 1'b0;

        // Single request on line 3
        we_mask = 1'b1; mask_in = 8'hFF;
        expect_out("mask_ff", 8'h00, 0, 8'h00, 0, 3'd0); tick_check();
        we_mask = 1'b0; irq_in = 8'h08;
        expect_out("irq3_k", 8'h00, 0, 8'h00, 0, 3'd0); tick_check();
        irq_in = 8'h00;
        expect_out("irq3_k1", 8'h00, 0, 8'h00, 0, 3'd0); tick_check();
        expect_out("irq3_k2", 8'h08, 1, 8'h08, 0, 3'd0); tick_check();
        ack = 1'b1;
        expect_out("ack3", 8'h00, 0, 8'h00, 1, 3'd3); tick_check();
        ack = 1'b0; eoi = 1'b1;
        expect_out("eoi3", 8'h00, 0, 8'h00, 0, 3'd3); tick_check();
        eoi = 1'b0;
        expect_out("eoi_idle_hold", 8'h00, 0, 8'h00, 0, 3'd3); tick_check();

        // Simultaneous lines 5 and 1
        irq_in = 8'h22; tick();
        irq_in = 8'h00; tick();
        expect_out("dual_pend", 8'h02, 1, 8'h22, 0, 3'd3); tick_check();
        ack = 1'b1;
        expect_out("dual_ack1", 8'h00, 0, 8'h20, 1, 3'd1); tick_check();
        ack = 1'b0; eoi = 1'b1;
        expect_out("dual_eoi1", 8'h20, 1, 8'h20, 0, 3'd1); tick_check();
        eoi = 1'b0; ack = 1'b1;
        expect_out("dual_ack5", 8'h00, 0, 8'h00, 1, 3'd5); tick_check();
        ack = 1'b0; eoi = 1'b1;
        expect_out("dual_eoi5", 8'h00, 0, 8'h00, 0, 3'd5); tick_check();
        eoi = 1'b0;

        // Masked line still latches; ack without int_req ignored
        we_mask = 1'b1; mask_in = 8'h00; irq_in = 8'h01; tick();
        we_mask = 1'b0; irq_in = 8'h00; tick();
        expect_out("masked_pend", 8'h00, 0, 8'h01, 0, 3'd5); tick_check();
        ack = 1'b1;
        expect_out("ack_no_req", 8'h00, 0, 8'h01, 0, 3'd5); tick_check();
        ack = 1'b0; we_mask = 1'b1; mask_in = 8'h01;
        expect_out("unmask0", 8'h01, 1, 8'h01, 0, 3'd5); tick_check();
        we_mask = 1'b0; ack = 1'b1;
        expect_out("ack0", 8'h00, 0, 8'h00, 1, 3'd0); tick_check();
        ack = 1'b0; we_mask = 1'b1; mask_in = 8'hFF;
        expect_out("mask_in_svc", 8'h00, 0, 8'h00, 1, 3'd0); tick_check();
        we_mask = 1'b0;

        // No nesting: ack and new edge during service
        irq_in = 8'h04; ack = 1'b1; tick();
        irq_in = 8'h00; ack = 1'b0; tick();
        expect_out("svc_pend2", 8'h00, 0, 8'h04, 1, 3'd0); tick_check();
        ack = 1'b1;
        expect_out("svc_ack_ign", 8'h00, 0, 8'h04, 1, 3'd0); tick_check();
        ack = 1'b0; eoi = 1'b1;
        expect_out("svc_eoi", 8'h04, 1, 8'h04, 0, 3'd0); tick_check();

        // ack+eoi together: IDLE takes ack, SERVICE takes eoi
        ack = 1'b1; eoi = 1'b1;
        expect_out("both_idle", 8'h00, 0, 8'h00, 1, 3'd2); tick_check();
        expect_out("both_svc", 8'h00, 0, 8'h00, 0, 3'd2); tick_check();
        ack = 1'b0; eoi = 1'b0;

        // New edge on line 4 arrives in the same cycle ack clears it
        irq_in = 8'h10; tick();
        irq_in = 8'h00; tick();
        expect_out("l4_pend", 8'h10, 1, 8'h10, 0, 3'd2); tick_check();
        irq_in = 8'h10; tick();
        irq_in = 8'h00;
        expect_out("l4_pre_ack", 8'h10, 1, 8'h10, 0, 3'd2); tick_check();
        ack = 1'b1;
        expect_out("l4_set_wins", 8'h00, 0, 8'h10, 1, 3'd4); tick_check();
        ack = 1'b0; eoi = 1'b1;
        expect_out("l4_eoi", 8'h10, 1, 8'h10, 0, 3'd4); tick_check();
        eoi = 1'b0;

        // Reset mid-service with pending 0x81
        irq_in = 8'h81; ack = 1'b1; tick();
        irq_in = 8'h00; ack = 1'b0; tick();
        expect_out("pre_rst", 8'h00, 0, 8'h81, 1, 3'd4); tick_check();
        reset = 1'b1;
        expect_out("rst_svc", 8'h00, 0, 8'h00, 0, 3'd0); tick_check();
        reset = 1'b0; irq_in = 8'h01; tick();
        irq_in = 8'h00; tick();
        expect_out("rst_mask0", 8'h00, 0, 8'h01, 0, 3'd0); tick_check();

        // Line held high through reset release
        reset = 1'b1; irq_in = 8'h02;
        expect_out("hold_rst", 8'h00, 0, 8'h00, 0, 3'd0); tick_check();
        reset = 1'b0;
        expect_out("hold_r", 8'h00, 0, 8'h00, 0, 3'd0); tick_check();
        expect_out("hold_r1", 8'h00, 0, 8'h00, 0, 3'd0); tick_check();
        expect_out("hold_r2", 8'h00, 0, 8'h02, 0, 3'd0); tick_check();
        we_mask = 1'b1; mask_in = 8'h02;
        expect_out("hold_unmask", 8'h02, 1, 8'h02, 0, 3'd0); tick_check();
        we_mask = 1'b0; ack = 1'b1;
        expect_out("hold_ack", 8'h00, 0, 8'h00, 1, 3'd1); tick_check();
        ack = 1'b0;
        expect_out("hold_one_edge", 8'h00, 0, 8'h00, 1, 3'd1); tick_check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
